cfs_tx_arb: RTL and testbench

//  - Round-robin arbiter that shares one MD TX interface between NUM_REQ TX FIFO pop ports.
//  - Each requester presents {size, offset, data} in the TX FIFO word format.
//  - A registered output stage holds the granted word until md_tx_ready accepts it.
//  - Sits between the per-channel TX FIFOs and the single md_tx_* pins of the aligner top.

---
 rtl/cfs_algn_pkg.sv | 41 ++++
 rtl/cfs_rr_picker.sv | 28 ++
 rtl/cfs_tx_arb.sv | 108 ++++++++++
 tb/tb_cfs_tx_arb.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/cfs_algn_pkg.sv
// Aligner-wide TX FIFO word format: field positions, word struct and arbiter state encoding.
// Shared by cfs_tx_arb, cfs_tx_ctrl and the TX FIFO.
package cfs_algn_pkg;

  // Offset addresses a byte lane; size counts bytes 1..DW/8, hence one extra bit.
  function automatic int algn_offset_w(int dw);
    return (dw / 8 > 1) ? $clog2(dw / 8) : 1;
  endfunction

  function automatic int algn_size_w(int dw);
    return $clog2(dw / 8) + 1;
  endfunction

  function automatic int algn_fifo_w(int dw);
    return dw + algn_offset_w(dw) + algn_size_w(dw);
  endfunction

  localparam int TX_DATA_W   = 32;
  localparam int TX_OFFSET_W = algn_offset_w(TX_DATA_W);
  localparam int TX_SIZE_W   = algn_size_w(TX_DATA_W);
  localparam int TX_FIFO_W   = algn_fifo_w(TX_DATA_W);

  localparam int TX_DATA_LSB   = 0;
  localparam int TX_DATA_MSB   = TX_DATA_LSB + TX_DATA_W - 1;
  localparam int TX_OFFSET_LSB = TX_DATA_MSB + 1;
  localparam int TX_OFFSET_MSB = TX_OFFSET_LSB + TX_OFFSET_W - 1;
  localparam int TX_SIZE_LSB   = TX_OFFSET_MSB + 1;
  localparam int TX_SIZE_MSB   = TX_SIZE_LSB + TX_SIZE_W - 1;

  typedef struct packed {
    logic [TX_SIZE_W-1:0]   size;
    logic [TX_OFFSET_W-1:0] offset;
    logic [TX_DATA_W-1:0]   data;
  } cfs_tx_word_t;

  typedef enum logic {
    TX_EMPTY = 1'b0,
    TX_FULL  = 1'b1
  } tx_state_e;

endpackage

// File: rtl/cfs_rr_picker.sv
// Rotate-priority encoder: first set req bit strictly after 'last', wrapping to 0.
module cfs_rr_picker #(
  parameter  int NUM_REQ = 2,
  localparam int IW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      last,
  output logic               gnt_valid,
  output logic [IW-1:0]      gnt_idx
);

  int idx;

  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    idx       = 0;
    // k=NUM_REQ revisits 'last' itself, so a lone requester keeps winning.
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last) + k) % NUM_REQ;
      if (!gnt_valid && req[idx]) begin
        gnt_valid = 1'b1;
        gnt_idx   = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/cfs_tx_arb.sv
// Round-robin arbiter sharing one MD TX port between NUM_REQ TX FIFO pop ports.
// Optional per-requester handshake counters: define CFS_TX_ARB_CNT_EN.
module cfs_tx_arb
  import cfs_algn_pkg::*;
#(
  parameter  int ALGN_DATA_WIDTH   = 32,
  parameter  int NUM_REQ           = 2,
  localparam int ALGN_OFFSET_WIDTH = algn_offset_w(ALGN_DATA_WIDTH),
  localparam int ALGN_SIZE_WIDTH   = algn_size_w(ALGN_DATA_WIDTH),
  localparam int FIFO_DATA_WIDTH   = algn_fifo_w(ALGN_DATA_WIDTH),
  localparam int REQ_IDX_WIDTH     = $clog2(NUM_REQ)
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [NUM_REQ-1:0]                   pop_valid,
  input  logic [NUM_REQ*FIFO_DATA_WIDTH-1:0]   pop_data,
  output logic [NUM_REQ-1:0]                   pop_ready,
  output logic                                 md_tx_valid,
  output logic [ALGN_DATA_WIDTH-1:0]           md_tx_data,
  output logic [ALGN_OFFSET_WIDTH-1:0]         md_tx_offset,
  output logic [ALGN_SIZE_WIDTH-1:0]           md_tx_size,
  input  logic                                 md_tx_ready,
  output logic [REQ_IDX_WIDTH-1:0]             md_tx_src
`ifdef CFS_TX_ARB_CNT_EN
  ,
  input  logic                                 cnt_clr,
  output logic [NUM_REQ*16-1:0]                cnt
`endif
);

  tx_state_e                                state_q, state_d;
  logic [NUM_REQ-1:0][FIFO_DATA_WIDTH-1:0]  words;
  logic [FIFO_DATA_WIDTH-1:0]               gnt_word;
  logic [REQ_IDX_WIDTH-1:0]                 last_grant;
  logic [REQ_IDX_WIDTH-1:0]                 gnt_idx;
  logic                                     gnt_valid;
  logic                                     load_en;
  logic                                     load;

  assign words    = pop_data;
  assign gnt_word = words[gnt_idx];

  cfs_rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .req       (pop_valid),
    .last      (last_grant),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  // Output slot is free when empty or being drained this cycle.
  assign load_en = (state_q == TX_EMPTY) || md_tx_ready;
  assign load    = load_en && gnt_valid && !reset;

  always_comb begin
    pop_ready = '0;
    if (load) pop_ready[gnt_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= TX_EMPTY;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      TX_EMPTY: if (gnt_valid) state_d = TX_FULL;
      TX_FULL:  if (md_tx_ready) state_d = gnt_valid ? TX_FULL : TX_EMPTY;
      default:  state_d = TX_EMPTY;
    endcase
  end

  always_comb begin
    md_tx_valid = (state_q == TX_FULL);
  end

  // Payload registers only move on a grant; an empty slot keeps the stale word.
  always_ff @(posedge clk) begin
    if (reset) begin
      md_tx_data   <= '0;
      md_tx_offset <= '0;
      md_tx_size   <= '0;
      md_tx_src    <= '0;
      last_grant   <= REQ_IDX_WIDTH'(NUM_REQ - 1);
    end else if (load) begin
      {md_tx_size, md_tx_offset, md_tx_data} <= gnt_word;
      md_tx_src  <= gnt_idx;
      last_grant <= gnt_idx;
    end
  end

`ifdef CFS_TX_ARB_CNT_EN
  logic hs;
  assign hs = md_tx_valid && md_tx_ready;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_cnt
    logic [15:0] c;
    always_ff @(posedge clk) begin
      if (reset || cnt_clr)
        c <= '0;
      else if (hs && (md_tx_src == REQ_IDX_WIDTH'(i)) && (c != 16'hFFFF))
        c <= c + 16'd1;
    end
    assign cnt[i*16 +: 16] = c;
  end
`endif

endmodule

// File: tb/tb_cfs_tx_arb.sv
// Directed bench for cfs_tx_arb (NUM_REQ=2, 32-bit data); counter tests when CFS_TX_ARB_CNT_EN is defined.
module tb_cfs_tx_arb;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  pop_valid;
  logic [73:0] pop_data;
  logic [1:0]  pop_ready;
  logic        md_tx_valid;
  logic [31:0] md_tx_data;
  logic [1:0]  md_tx_offset;
  logic [2:0]  md_tx_size;
  logic        md_tx_ready;
  logic [0:0]  md_tx_src;
`ifdef CFS_TX_ARB_CNT_EN
  logic        cnt_clr;
  logic [31:0] cnt;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  cfs_tx_arb #(.ALGN_DATA_WIDTH(32), .NUM_REQ(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .pop_valid    (pop_valid),
    .pop_data     (pop_data),
    .pop_ready    (pop_ready),
    .md_tx_valid  (md_tx_valid),
    .md_tx_data   (md_tx_data),
    .md_tx_offset (md_tx_offset),
    .md_tx_size   (md_tx_size),
    .md_tx_ready  (md_tx_ready),
    .md_tx_src    (md_tx_src)
`ifdef CFS_TX_ARB_CNT_EN
    ,
    .cnt_clr      (cnt_clr),
    .cnt          (cnt)
`endif
  );

  function automatic logic [36:0] mk(input logic [2:0] s, input logic [1:0] o, input logic [31:0] d);
    return {s, o, d};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    pop_valid   = 2'b00;
    md_tx_ready = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; pop_valid = 2'b00; md_tx_ready = 1'b0; pop_data = '0;
`ifdef CFS_TX_ARB_CNT_EN
    cnt_clr = 1'b0;
`endif
    tick(); tick();
    total++; if (md_tx_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0h exp=0", md_tx_valid); end
    total++; if (md_tx_src !== 1'b0) begin bad++; $display("FAIL reset_src got=%0h exp=0", md_tx_src); end
    total++; if ({md_tx_size, md_tx_offset, md_tx_data} !== 37'd0) begin bad++; $display("FAIL reset_word got=%0h exp=0", {md_tx_size, md_tx_offset, md_tx_data}); end
    total++; if (pop_ready !== 2'b00) begin bad++; $display("FAIL reset_pop_ready got=%0b exp=00", pop_ready); end
    pop_valid = 2'b11; #1;
    total++; if (pop_ready !== 2'b00) begin bad++; $display("FAIL reset_pop_ready_req got=%0b exp=00", pop_ready); end
    tick();
    pop_valid = 2'b00; reset = 1'b0; #1;
    total++; if (md_tx_valid !== 1'b0) begin bad++; $display("FAIL reset_hold_valid got=%0h exp=0", md_tx_valid); end
  endtask

  // last_grant resets to 1, so requester 0 wins first.
  task automatic test_alternate();
    logic [31:0] exp_d;
    pop_data = {mk(3'd2, 2'd2, 32'hB000_0001), mk(3'd1, 2'd1, 32'hA000_0000)};
    pop_valid = 2'b11; md_tx_ready = 1'b1; #1;
    for (int k = 0; k < 4; k++) begin
      exp_d = (k % 2) ? 32'hB000_0001 : 32'hA000_0000;
      total++; if (pop_ready !== (2'b01 << (k % 2))) begin bad++; $display("FAIL alt_grant k=%0d got=%0b exp=%0b", k, pop_ready, 2'b01 << (k % 2)); end
      tick();
      total++; if (md_tx_valid !== 1'b1 || md_tx_src !== 1'((k % 2)) || md_tx_data !== exp_d) begin
        bad++; $display("FAIL alt_out k=%0d got v=%0h src=%0h d=%0h exp v=1 src=%0d d=%0h", k, md_tx_valid, md_tx_src, md_tx_data, k % 2, exp_d);
      end
    end
    drain();
    total++; if (md_tx_valid !== 1'b0) begin bad++; $display("FAIL alt_drain got=%0h exp=0", md_tx_valid); end
  endtask

  task automatic test_backpressure();
    pop_data = {mk(3'd2, 2'd2, 32'hB000_0001), mk(3'd2, 2'd1, 32'hA5A5_0001)};
    pop_valid = 2'b01; md_tx_ready = 1'b0; #1;
    total++; if (pop_ready !== 2'b01) begin bad++; $display("FAIL bp_first_grant got=%0b exp=01", pop_ready); end
    tick();
    pop_data = {mk(3'd2, 2'd2, 32'hB000_0001), mk(3'd7, 2'd3, 32'h1111_1111)};
    pop_valid = 2'b11; #1;
    for (int k = 0; k < 5; k++) begin
      total++; if (pop_ready !== 2'b00 || md_tx_valid !== 1'b1 || md_tx_data !== 32'hA5A5_0001 ||
                   md_tx_offset !== 2'd1 || md_tx_size !== 3'd2 || md_tx_src !== 1'b0) begin
        bad++; $display("FAIL bp_stable k=%0d got pr=%0b v=%0h d=%0h o=%0h s=%0h src=%0h exp pr=00 v=1 d=a5a50001 o=1 s=2 src=0",
                        k, pop_ready, md_tx_valid, md_tx_data, md_tx_offset, md_tx_size, md_tx_src);
      end
      tick();
    end
    md_tx_ready = 1'b1; #1;
    total++; if (pop_ready !== 2'b10) begin bad++; $display("FAIL bp_release_grant got=%0b exp=10", pop_ready); end
    tick();
    total++; if (md_tx_valid !== 1'b1 || md_tx_src !== 1'b1 || md_tx_data !== 32'hB000_0001) begin
      bad++; $display("FAIL bp_refill got v=%0h src=%0h d=%0h exp v=1 src=1 d=b0000001", md_tx_valid, md_tx_src, md_tx_data);
    end
    drain();
  endtask

  task automatic test_single();
    pop_valid = 2'b10; md_tx_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      pop_data = {mk(3'd4, 2'd0, 32'h1000 + k), mk(3'd1, 2'd1, 32'hFFFF_0000)}; #1;
      total++; if (pop_ready !== 2'b10) begin bad++; $display("FAIL single_grant k=%0d got=%0b exp=10", k, pop_ready); end
      tick();
      total++; if (md_tx_valid !== 1'b1 || md_tx_src !== 1'b1 || md_tx_data !== 32'h1000 + k) begin
        bad++; $display("FAIL single_out k=%0d got v=%0h src=%0h d=%0h exp v=1 src=1 d=%0h", k, md_tx_valid, md_tx_src, md_tx_data, 32'h1000 + k);
      end
    end
    pop_valid = 2'b00; #1;
    total++; if (pop_ready !== 2'b00) begin bad++; $display("FAIL single_idle_ready got=%0b exp=00", pop_ready); end
    tick();
    total++; if (md_tx_valid !== 1'b0 || md_tx_data !== 32'h1003) begin
      bad++; $display("FAIL single_drop got v=%0h d=%0h exp v=0 d=1003", md_tx_valid, md_tx_data);
    end
  endtask

  task automatic test_fields();
    pop_data = {mk(3'd5, 2'd2, 32'h5555_AAAA), mk(3'd4, 2'd0, 32'hDEAD_BEEF)};
    pop_valid = 2'b01; md_tx_ready = 1'b1; #1;
    tick();
    total++; if (md_tx_size !== 3'd4 || md_tx_offset !== 2'd0 || md_tx_data !== 32'hDEAD_BEEF || md_tx_src !== 1'b0) begin
      bad++; $display("FAIL fields_a got s=%0h o=%0h d=%0h src=%0h exp s=4 o=0 d=deadbeef src=0", md_tx_size, md_tx_offset, md_tx_data, md_tx_src);
    end
    pop_data = {mk(3'd5, 2'd2, 32'h5555_AAAA), mk(3'd1, 2'd3, 32'h0123_4567)};
    tick();
    total++; if (md_tx_size !== 3'd1 || md_tx_offset !== 2'd3 || md_tx_data !== 32'h0123_4567) begin
      bad++; $display("FAIL fields_b got s=%0h o=%0h d=%0h exp s=1 o=3 d=01234567", md_tx_size, md_tx_offset, md_tx_data);
    end
    drain();
  endtask

`ifdef CFS_TX_ARB_CNT_EN
  task automatic test_cnt();
    pop_valid = 2'b00; md_tx_ready = 1'b1; cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    total++; if (cnt !== 32'd0) begin bad++; $display("FAIL cnt_clr0 got=%0h exp=0", cnt); end
    pop_data = {mk(3'd4, 2'd0, 32'h2222_0000), mk(3'd4, 2'd0, 32'h1111_0000)};
    pop_valid = 2'b01; tick(); tick(); tick();
    pop_valid = 2'b10; tick(); tick();
    pop_valid = 2'b00; tick();
    total++; if (cnt[15:0] !== 16'd3 || cnt[31:16] !== 16'd2) begin
      bad++; $display("FAIL cnt_counts got c0=%0d c1=%0d exp c0=3 c1=2", cnt[15:0], cnt[31:16]);
    end
    // Clear lands on the same edge as a req0 handshake.
    pop_valid = 2'b01; tick();
    cnt_clr = 1'b1; tick();
    cnt_clr = 1'b0;
    total++; if (cnt !== 32'd0) begin bad++; $display("FAIL cnt_clr_wins got=%0h exp=0", cnt); end
    for (int k = 0; k < 65540; k++) tick();
    total++; if (cnt[15:0] !== 16'hFFFF || cnt[31:16] !== 16'd0) begin
      bad++; $display("FAIL cnt_sat got c0=%0h c1=%0h exp c0=ffff c1=0", cnt[15:0], cnt[31:16]);
    end
    pop_valid = 2'b00; tick();
    total++; if (cnt[15:0] !== 16'hFFFF) begin bad++; $display("FAIL cnt_sat_hold got=%0h exp=ffff", cnt[15:0]); end
  endtask
`endif

  initial begin
    test_reset();
    test_alternate();
    test_backpressure();
    test_single();
    test_fields();
`ifdef CFS_TX_ARB_CNT_EN
    test_cnt();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
